mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single physical main-memory port between the instruction-cache miss path (I) and the data-cache miss/write-back path (D).
- Sits between the cache/TLB CPU core and the memory/I-O split logic.
- Drives the memory-side access/write/address/data signals and consumes the ready signal.
- D has priority. A starvation counter guarantees forward progress for I fetches.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_D_WINS, 4, maximum consecutive D grants while I is pending before I is forced ahead (legal range 1..15).
- CW, 4, width of the starvation counter (must hold MAX_D_WINS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-high reset.
- i_req  in  1  I request; held high until i_ack.
- i_a  in  AW  I address; stable while i_req.
- i_rdata  out  DW  read data to I; valid only in the i_ack cycle.
- i_ack  out  1  one-cycle completion pulse to I.
- d_req  in  1  D request; held high until d_ack.
- d_write  in  1  D is a write; stable while d_req.
- d_a  in  AW  D address; stable while d_req.
- d_wdata  in  DW  D write data; stable while d_req.
- d_rdata  out  DW  read data to D; valid only in the d_ack cycle.
- d_ack  out  1  one-cycle completion pulse to D.
- m_a  out  AW  memory address.
- m_d_w  out  DW  memory write data.
- m_d_r  in  DW  memory read data.
- m_access  out  1  memory access request.
- m_write  out  1  memory write enable.
- m_ready  in  1  memory completion; valid only while m_access is high.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States: IDLE, GNT_I, GNT_D. State register and starvation counter dcnt[CW-1:0] are the only flops.
- Reset (asynchronous, clr=1): state=IDLE, dcnt=0. All outputs are 0 during and after reset: m_access, m_write, i_ack, d_ack, busy, m_a, m_d_w, i_rdata, d_rdata.
- IDLE:
  - m_access=0, m_write=0, m_a=0, m_d_w=0.
  - Arbitration is evaluated every cycle:
    - d_req and not (i_req and dcnt==MAX_D_WINS) -> GNT_D.
    - else i_req -> GNT_I.
    - else stay in IDLE.
- GNT_I:
  - m_access=1, m_write=0, m_a=i_a, m_d_w=0.
  - When m_ready=1: i_ack=1 and i_rdata=m_d_r, both combinational in that same cycle. Next state IDLE; dcnt<=0.
- GNT_D:
  - m_access=1, m_write=d_write, m_a=d_a, m_d_w=d_wdata.
  - When m_ready=1: d_ack=1; d_rdata=m_d_r if d_write=0, else d_rdata=0. Next state IDLE.
  - On that same completion: dcnt<=dcnt+1 if i_req=1 (saturating at MAX_D_WINS); dcnt<=0 if i_req=0.
- Grant is held until m_ready. No preemption; the other request waits.
- Mandatory gap: after every completion the arbiter spends at least one cycle in IDLE with m_access=0. Minimum period is 2 cycles per transaction plus memory wait cycles.
- Latency: request seen in IDLE at edge N -> m_access high in cycle N+1. Ack occurs in the first cycle of the grant where m_ready=1.
- m_ready is ignored in IDLE. A stray m_ready never produces an ack.
- A requester dropping req before ack is a protocol violation. The arbiter still completes the memory transaction, and the ack is issued regardless.
- Simultaneous i_req and d_req with dcnt<MAX_D_WINS -> D wins. With dcnt==MAX_D_WINS -> I wins and dcnt clears on I completion.
- A request arriving in the ack cycle of the other requester is arbitrated in the following IDLE cycle.
- Reset asserted mid-transaction: return to IDLE immediately, drop m_access, no ack pulse. Requesters must re-request after reset.
- i_ack and d_ack are never high in the same cycle.
- busy = (state != IDLE).

Test Plan:
- Single I read: i_req=1, i_a=0x0000_0040; memory returns m_ready after 3 wait cycles with m_d_r=0x8C220004 -> m_access high cycles 1-4, m_write=0, m_a=0x40; i_ack one pulse with i_rdata=0x8C220004; m_access low the next cycle.
- D write: d_req=1, d_write=1, d_a=0x0000_0100, d_wdata=0xDEADBEEF -> m_write=1, m_a=0x100, m_d_w=0xDEADBEEF throughout the grant; d_ack pulse; d_rdata=0.
- Simultaneous requests at reset exit (dcnt=0) -> GNT_D first, then IDLE for one cycle, then GNT_I; the acks are ordered d_ack then i_ack.
- Starvation, MAX_D_WINS=4: d_req and i_req held continuously -> exactly 4 D grants, then 1 I grant, then D again; dcnt returns to 0 after the I completion.
- Stray m_ready=1 while IDLE, and m_ready asserted during clr -> no ack, state stays IDLE.
- clr pulsed during a GNT_D wait -> m_access falls asynchronously, no d_ack; after release with d_req still high, a fresh grant begins one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between the I-fetch and D miss paths.
// D has priority; a starvation counter forces I ahead after MAX_D_WINS D grants.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MAX_D_WINS = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          i_req,
  input  logic [AW-1:0] i_a,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [AW-1:0] d_a,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic [AW-1:0] m_a,
  output logic [DW-1:0] m_d_w,
  input  logic [DW-1:0] m_d_r,
  output logic          m_access,
  output logic          m_write,
  input  logic          m_ready,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;

  localparam logic [CW-1:0] DMAX = CW'(MAX_D_WINS);

  logic [1:0]    state, state_nxt;
  logic [CW-1:0] dcnt, dcnt_nxt;
  logic          starved;

  assign starved = i_req && (dcnt == DMAX);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    m_access  = 1'b0;
    m_write   = 1'b0;
    m_a       = '0;
    m_d_w     = '0;
    i_ack     = 1'b0;
    i_rdata   = '0;
    d_ack     = 1'b0;
    d_rdata   = '0;
    unique case (state)
      IDLE: begin
        if (d_req && !starved)
          state_nxt = GNT_D;
        else if (i_req)
          state_nxt = GNT_I;
      end
      GNT_I: begin
        m_access = 1'b1;
        m_a      = i_a;
        if (m_ready) begin
          i_ack     = 1'b1;
          i_rdata   = m_d_r;
          state_nxt = IDLE;
          dcnt_nxt  = '0;
        end
      end
      GNT_D: begin
        m_access = 1'b1;
        m_write  = d_write;
        m_a      = d_a;
        m_d_w    = d_wdata;
        if (m_ready) begin
          d_ack     = 1'b1;
          d_rdata   = d_write ? '0 : m_d_r;
          state_nxt = IDLE;
          // Count only D wins that overtook a waiting I fetch
          if (!i_req)
            dcnt_nxt = '0;
          else if (dcnt != DMAX)
            dcnt_nxt = dcnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a
// transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          i_req;
  logic [AW-1:0] i_a;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          d_req;
  logic          d_write;
  logic [AW-1:0] d_a;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic [AW-1:0] m_a;
  logic [DW-1:0] m_d_w;
  logic [DW-1:0] m_d_r;
  logic          m_access;
  logic          m_write;
  logic          m_ready;
  logic          busy;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_D_WINS(MAXW), .CW(CW)
  ) dut (
    .clk(clk), .clr(clr),
    .i_req(i_req), .i_a(i_a), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_write(d_write), .d_a(d_a), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_a(m_a), .m_d_w(m_d_w), .m_d_r(m_d_r),
    .m_access(m_access), .m_write(m_write), .m_ready(m_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // who owns the port: 0 nobody, 1 I, 2 D
  int cur = 0;
  int hist_who[$];
  bit hist_iw[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // trailing D completions that each happened while I was waiting
  function automatic int streak();
    int n = 0;
    for (int k = hist_who.size() - 1; k >= 0; k--) begin
      if (hist_who[k] != 2 || !hist_iw[k]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step();
    logic [AW-1:0] ea;
    logic [DW-1:0] ew, eir, edr;
    bit eacc, ewr, eia, eda;
    if (clr) begin
      cur = 0;
      hist_who.delete();
      hist_iw.delete();
    end
    eacc = (cur != 0);
    ea   = (cur == 1) ? i_a : (cur == 2) ? d_a : '0;
    ewr  = (cur == 2) && d_write;
    ew   = (cur == 2) ? d_wdata : '0;
    eia  = (cur == 1) && m_ready;
    eda  = (cur == 2) && m_ready;
    eir  = eia ? m_d_r : '0;
    edr  = (eda && !d_write) ? m_d_r : '0;
    chk("m_access", 64'(m_access), 64'(eacc));
    chk("busy", 64'(busy), 64'(eacc));
    chk("m_a", 64'(m_a), 64'(ea));
    chk("m_write", 64'(m_write), 64'(ewr));
    chk("m_d_w", 64'(m_d_w), 64'(ew));
    chk("i_ack", 64'(i_ack), 64'(eia));
    chk("i_rdata", 64'(i_rdata), 64'(eir));
    chk("d_ack", 64'(d_ack), 64'(eda));
    chk("d_rdata", 64'(d_rdata), 64'(edr));
    if (clr) begin
      cur = 0;
    end else if (cur == 0) begin
      if (d_req && !(i_req && streak() >= MAXW)) cur = 2;
      else if (i_req) cur = 1;
    end else if (m_ready) begin
      hist_who.push_back(cur);
      hist_iw.push_back(i_req);
      cur = 0;
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  int acc_n;
  int acks[$];
  bit i_done, d_done;

  initial begin
    clr = 1'b1; i_req = 0; i_a = '0; d_req = 0; d_write = 0;
    d_a = '0; d_wdata = '0; m_d_r = '0; m_ready = 1'b1;
    @(posedge clk); #1;
    // reset state with a stray ready during clr
    smp();
    chk("rst_acc", 64'(m_access), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_iack", 64'(i_ack), 64'd0);
    adv();
    clr = 0; m_ready = 0;

    // single I read, three wait cycles
    i_req = 1; i_a = 32'h40;
    smp(); chk("t1_idle", 64'(m_access), 64'd0); adv();
    acc_n = 0;
    for (int k = 0; k < 4; k++) begin
      m_ready = (k == 3);
      m_d_r = (k == 3) ? 32'h8C22_0004 : 32'h0;
      smp();
      if (m_access) acc_n++;
      chk("t1_ma", 64'(m_a), 64'h40);
      chk("t1_wr", 64'(m_write), 64'd0);
      if (k == 3) begin
        chk("t1_iack", 64'(i_ack), 64'd1);
        chk("t1_irdata", 64'(i_rdata), 64'h8C22_0004);
      end
      adv();
    end
    chk("t1_acc_cycles", 64'(acc_n), 64'd4);
    i_req = 0; m_ready = 0;
    smp(); chk("t1_gap", 64'(m_access), 64'd0); adv();

    // D write
    d_req = 1; d_write = 1; d_a = 32'h100; d_wdata = 32'hDEAD_BEEF;
    smp(); adv();
    for (int k = 0; k < 3; k++) begin
      m_ready = (k == 2); m_d_r = 32'h1234_5678;
      smp();
      chk("t2_wr", 64'(m_write), 64'd1);
      chk("t2_ma", 64'(m_a), 64'h100);
      chk("t2_mdw", 64'(m_d_w), 64'hDEAD_BEEF);
      if (k == 2) begin
        chk("t2_dack", 64'(d_ack), 64'd1);
        chk("t2_drdata", 64'(d_rdata), 64'd0);
      end
      adv();
    end
    d_req = 0; d_write = 0; m_ready = 0;
    smp(); chk("t2_gap", 64'(m_access), 64'd0); adv();

    // simultaneous requests straight out of reset; stray ready in IDLE
    clr = 1; smp(); adv(); clr = 0;
    i_req = 1; i_a = 32'h80; d_req = 1; d_a = 32'h300; m_ready = 1;
    smp(); chk("t3_idle_noack", 64'(i_ack | d_ack), 64'd0); adv();
    smp();
    chk("t3_dfirst", 64'(d_ack), 64'd1);
    chk("t3_ino", 64'(i_ack), 64'd0);
    adv(); d_req = 0;
    smp(); chk("t3_gap", 64'(m_access), 64'd0);
    chk("t3_stray", 64'(i_ack | d_ack), 64'd0); adv();
    smp(); chk("t3_ithen", 64'(i_ack), 64'd1); adv();
    i_req = 0; m_ready = 0;
    smp(); adv();

    // starvation: both held, memory always ready
    clr = 1; smp(); adv(); clr = 0;
    i_req = 1; d_req = 1; m_ready = 1;
    acks.delete();
    for (int k = 0; k < 20; k++) begin
      smp();
      if (d_ack) acks.push_back(2);
      if (i_ack) acks.push_back(1);
      adv();
    end
    chk("t4_nacks", 64'(acks.size()), 64'd10);
    for (int k = 0; k < acks.size(); k++)
      chk($sformatf("t4_ack%0d", k), 64'(acks[k]),
          64'((k % (MAXW + 1) == MAXW) ? 1 : 2));
    i_req = 0; d_req = 0; m_ready = 0;
    smp(); adv();

    // clr during a D wait
    d_req = 1; d_a = 32'h200;
    smp(); adv();
    smp(); chk("t6_granted", 64'(m_access), 64'd1); adv();
    #2 clr = 1;
    #1;
    chk("t6_async_acc", 64'(m_access), 64'd0);
    chk("t6_async_busy", 64'(busy), 64'd0);
    m_ready = 1;
    #1 chk("t6_no_dack", 64'(d_ack), 64'd0);
    smp(); adv();
    clr = 0; m_ready = 0;
    smp(); chk("t6_rel_idle", 64'(m_access), 64'd0); adv();
    smp(); chk("t6_regrant", 64'(m_access), 64'd1); adv();
    m_ready = 1;
    smp(); chk("t6_dack", 64'(d_ack), 64'd1); adv();
    d_req = 0; m_ready = 0;
    smp(); adv();

    // randomized traffic against the model
    i_done = 0; d_done = 0;
    for (int c = 0; c < 600; c++) begin
      if (i_done) begin
        i_req = 0; i_done = 0;
      end else if (!i_req && $urandom_range(2) != 0) begin
        i_req = 1; i_a = $urandom;
      end
      if (d_done) begin
        d_req = 0; d_done = 0;
      end else if (!d_req && $urandom_range(2) != 0) begin
        d_req = 1; d_a = $urandom; d_wdata = $urandom;
        d_write = $urandom_range(1) != 0;
      end
      m_ready = $urandom_range(1) != 0;
      m_d_r = $urandom;
      smp();
      if (i_ack) i_done = 1;
      if (d_ack) d_done = 1;
      adv();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
